imem_fetch_queue: RTL and testbench



---
 rtl/imem_fetch_queue.sv | 138 +++++++++++++
 tb/tb_imem_fetch_queue.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_queue.sv
// Instruction-fetch front end: req/ack fetch FSM feeding a PC-tagged FIFO toward the core.
// Optional build macro FETCH_STATS_EN adds stat_fetched / stat_discarded event counters.
module imem_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_discarded
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } fetch_state_t;

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic          discard;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic        ack_fire;
    logic        push;
    logic        pop;
    logic        space_ok;
    logic        issue;
    logic [31:0] fetch_pc_adv;
    logic [31:0] next_fetch_pc;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^redirect_addr[1:0];

    // Redirect suppresses both FIFO ports; the acked word of the old stream is dropped.
    assign ack_fire      = (state == S_WAIT) && mem_ack;
    assign push          = ack_fire && !discard && !redirect;
    assign pop           = instr_valid && instr_ready && !redirect;
    assign space_ok      = (count + CW'(push)) < CW'(DEPTH);
    assign issue         = !redirect && space_ok;
    assign fetch_pc_adv  = push ? fetch_pc + 32'd4 : fetch_pc;
    assign next_fetch_pc = redirect ? {redirect_addr[31:2], 2'b00} : fetch_pc_adv;

    assign mem_req     = (state == S_WAIT);
    assign instr_valid = (count != '0);
    assign instr_data  = instr_valid ? data_mem[rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : 32'h0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            mem_addr <= RESET_PC;
            fetch_pc <= RESET_PC;
            discard  <= 1'b0;
        end else begin
            fetch_pc <= next_fetch_pc;
            if (state == S_WAIT && !mem_ack) begin
                // Address must stay stable until ack; a redirect only marks the reply as stale.
                if (redirect) begin
                    discard <= 1'b1;
                end
            end else begin
                discard <= 1'b0;
                if (issue) begin
                    state    <= S_WAIT;
                    mem_addr <= fetch_pc_adv;
                end else begin
                    state <= S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; outputs are masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= mem_rdata;
            pc_mem[wr_ptr]   <= fetch_pc;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fetched   <= 32'h0;
            stat_discarded <= 32'h0;
        end else begin
            if (push) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (ack_fire && (discard || redirect)) begin
                stat_discarded <= stat_discarded + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_queue.sv
// Directed bench for imem_fetch_queue: streaming, backpressure, slow ack, redirects, reset, pc wrap.
// Build with FETCH_STATS_EN defined to also check the statistics counters.
module tb_imem_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_discarded;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    imem_fetch_queue #(
        .DEPTH   (4),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_data   (instr_data),
        .instr_pc     (instr_pc),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched  (stat_fetched),
        .stat_discarded(stat_discarded)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Memory that answers every request in the cycle it is seen, data = ~address.
    task automatic auto_ack();
        mem_ack   = mem_req;
        mem_rdata = ~mem_addr;
    endtask

    initial begin
        reset         = 1'b1;
        redirect      = 1'b0;
        redirect_addr = 32'h0;
        instr_ready   = 1'b0;
        mem_ack       = 1'b0;
        mem_rdata     = 32'h0;

        // Reset state
        cycle();
        cycle();
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_req",   32'(mem_req),     32'd0);
        check("rst_addr",  mem_addr,         32'h0);
        check("rst_data",  instr_data,       32'h0);
        check("rst_pc",    instr_pc,         32'h0);

        // Streaming with immediate acks and ready=1
        reset       = 1'b0;
        instr_ready = 1'b1;
        cycle();
        check("s_req0",   32'(mem_req),     32'd1);
        check("s_addr0",  mem_addr,         32'h0);
        check("s_valid0", 32'(instr_valid), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = ~32'h0;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            check("s_valid", 32'(instr_valid), 32'd1);
            check("s_pc",    instr_pc,         32'(4 * (i - 1)));
            check("s_data",  instr_data,       ~32'(4 * (i - 1)));
            check("s_addr",  mem_addr,         32'(4 * i));
            mem_rdata = ~32'(4 * i);
        end

        // Backpressure: exactly DEPTH words fetched, then fetch stalls
        reset       = 1'b1;
        mem_ack     = 1'b0;
        instr_ready = 1'b0;
        cycle();
        reset = 1'b0;
        check("bp_rst_req", 32'(mem_req), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            auto_ack();
        end
        check("bp_full_req",   32'(mem_req),     32'd0);
        check("bp_full_valid", 32'(instr_valid), 32'd1);
        check("bp_full_pc",    instr_pc,         32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            auto_ack();
        end
        check("bp_hold_req",   32'(mem_req),     32'd0);
        check("bp_hold_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        cycle();
        auto_ack();
        check("bp_pop1_pc",  instr_pc,     32'h4);
        check("bp_pop1_req", 32'(mem_req), 32'd0);
        cycle();
        check("bp_pop2_pc",  instr_pc,     32'h8);
        check("bp_resume_req",  32'(mem_req), 32'd1);
        check("bp_resume_addr", mem_addr,     32'h10);
        auto_ack();
        cycle();
        auto_ack();
        check("bp_pop3_pc", instr_pc, 32'hC);
        cycle();
        auto_ack();
        check("bp_pop4_pc",   instr_pc,   32'h10);
        check("bp_pop4_data", instr_data, ~32'h10);

        // Ack delayed three cycles: request held stable
        reset   = 1'b1;
        mem_ack = 1'b0;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("slow_req",   32'(mem_req),     32'd1);
            check("slow_addr",  mem_addr,         32'h0);
            check("slow_valid", 32'(instr_valid), 32'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        cycle();
        check("slow_valid_rise", 32'(instr_valid), 32'd1);
        check("slow_pc",         instr_pc,         32'h0);
        check("slow_data",       instr_data,       32'h1234_5678);
        check("slow_next_addr",  mem_addr,         32'h4);

        // Redirect while the request to 8 is pending
        mem_rdata = 32'hFEED_0004;
        cycle();
        check("rd_pre_pc",   instr_pc, 32'h4);
        check("rd_pre_addr", mem_addr, 32'h8);
        mem_ack       = 1'b0;
        redirect      = 1'b1;
        redirect_addr = 32'h0000_0103;
        cycle();
        redirect = 1'b0;
        check("rd_flush_valid", 32'(instr_valid), 32'd0);
        check("rd_hold_req",    32'(mem_req),     32'd1);
        check("rd_hold_addr",   mem_addr,         32'h8);
        cycle();
        check("rd_hold2_addr", mem_addr, 32'h8);
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_0008;
        cycle();
        check("rd_drop_valid", 32'(instr_valid), 32'd0);
        check("rd_new_addr",   mem_addr,         32'h100);
        mem_rdata = 32'hCAFE_0100;
        cycle();
        mem_ack = 1'b0;
        check("rd_first_valid", 32'(instr_valid), 32'd1);
        check("rd_first_pc",    instr_pc,         32'h100);
        check("rd_first_data",  instr_data,       32'hCAFE_0100);
`ifdef FETCH_STATS_EN
        check("rd_stat_disc",  stat_discarded, 32'd1);
        check("rd_stat_fetch", stat_fetched,   32'd3);
`endif

        // Redirect coinciding with the ack for address 4
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        mem_ack   = 1'b1;
        mem_rdata = ~32'h0;
        cycle();
        check("rc_pre_addr", mem_addr, 32'h4);
        check("rc_pre_pc",   instr_pc, 32'h0);
        redirect      = 1'b1;
        redirect_addr = 32'd40;
        mem_rdata     = 32'hDEAD_0004;
        cycle();
        redirect = 1'b0;
        mem_ack  = 1'b0;
        check("rc_valid", 32'(instr_valid), 32'd0);
        check("rc_req",   32'(mem_req),     32'd0);
        cycle();
        check("rc_new_req",  32'(mem_req), 32'd1);
        check("rc_new_addr", mem_addr,     32'd40);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_AA28;
        cycle();
        check("rc_first_pc",   instr_pc,   32'd40);
        check("rc_first_data", instr_data, 32'h0000_AA28);
`ifdef FETCH_STATS_EN
        check("rc_stat_disc", stat_discarded, 32'd1);
`endif

        // Reset with a pending request and two queued entries
        instr_ready = 1'b0;
        mem_rdata   = 32'h0000_AA2C;
        cycle();
        check("rr_pre_addr",  mem_addr,         32'd48);
        check("rr_pre_valid", 32'(instr_valid), 32'd1);
        reset     = 1'b1;
        mem_rdata = 32'hBAD0_0030;
        cycle();
        reset       = 1'b0;
        mem_ack     = 1'b0;
        instr_ready = 1'b1;
        check("rr_valid", 32'(instr_valid), 32'd0);
        check("rr_req",   32'(mem_req),     32'd0);
        check("rr_addr",  mem_addr,         32'h0);
        cycle();
        check("rr_restart_req",  32'(mem_req), 32'd1);
        check("rr_restart_addr", mem_addr,     32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0F0F_0000;
        cycle();
        check("rr_first_pc",   instr_pc,   32'h0);
        check("rr_first_data", instr_data, 32'h0F0F_0000);

        // Fetch address wraps modulo 2^32
        mem_ack       = 1'b0;
        redirect      = 1'b1;
        redirect_addr = 32'hFFFF_FFFF;
        cycle();
        redirect = 1'b0;
        mem_ack  = 1'b1;
        cycle();
        check("wrap_addr", mem_addr, 32'hFFFF_FFFC);
        mem_rdata = 32'h7777_7777;
        cycle();
        mem_ack = 1'b0;
        check("wrap_pc",        instr_pc,   32'hFFFF_FFFC);
        check("wrap_data",      instr_data, 32'h7777_7777);
        check("wrap_next_addr", mem_addr,   32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
